seg7_scan_mux: RTL and testbench

// - Downstream consumer of the binary-to-BCD converter: takes a 4-digit packed BCD word plus its

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/seg7_scan_mux_if.sv | 24 ++
 rtl/seg7_decode.sv | 27 ++
 rtl/seg7_scan_mux.sv | 107 ++++++++++
 tb/tb_seg7_scan_mux.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit seven-segment scan multiplexer.
// Segment patterns are active-high, bit 0 = a .. bit 6 = g.
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  localparam logic [3:0] DIG_EN_N [0:3] = '{
    4'b0111, 4'b1011, 4'b1101, 4'b1110
  };
  localparam logic [3:0] DIG_OFF_N = 4'b1111;

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Value source <-> display driver bundle.
// slave = the scan mux, master = the value producer / pin observer.
interface seg7_scan_mux_if;

  logic [15:0] bcd_in;
  logic        bcd_valid;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        seg_dp;
  logic [3:0]  dig_en_n;
  logic        frame_sync;

  modport slave (
    input  bcd_in, bcd_valid, dp_in, blank_lz,
    output seg, seg_dp, dig_en_n, frame_sync
  );

  modport master (
    output bcd_in, bcd_valid, dp_in, blank_lz,
    input  seg, seg_dp, dig_en_n, frame_sync
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to seven-segment pattern.
// Non-decimal nibbles render as a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);

  always_comb begin
    pat = SEG_DASH;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 4-digit display driver with
// frame-aligned double buffering, zero blanking and dead time.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV    = 16000,
  parameter int DEAD_CYCLES = 160
) (
  input  logic            CLK,
  input  logic            RST_N,
  seg7_scan_mux_if.slave  bus
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   pending;
  logic          pending_flag;
  logic [15:0]   shadow;
  logic [15:0]   shadow_d;
  logic          frame_edge;
  logic          in_dead;
  logic [3:0]    lz;
  logic [3:0]    nib;
  logic [6:0]    dec;

  assign frame_edge = (cnt == '0) && (idx == 2'd0);

  if (DEAD_CYCLES == 0) begin : g_nodead
    assign in_dead = 1'b0;
  end else begin : g_dead
    assign in_dead = cnt < CW'(DEAD_CYCLES);
  end

  // The value committed this cycle is what gets drawn, so a
  // strobe landing on the boundary is visible without delay.
  always_comb begin
    shadow_d = shadow;
    if (frame_edge) begin
      if (bus.bcd_valid)
        shadow_d = bus.bcd_in;
      else if (pending_flag)
        shadow_d = pending;
    end
  end

  always_comb begin
    lz    = 4'b0000;
    lz[3] = shadow_d[15:12] == 4'd0;
    lz[2] = lz[3] && (shadow_d[11:8] == 4'd0);
    lz[1] = lz[2] && (shadow_d[7:4] == 4'd0);
  end

  assign nib = shadow_d[{idx, 2'b00} +: 4];

  seg7_decode u_dec (
    .nib (nib),
    .pat (dec)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt          <= '0;
      idx          <= 2'd0;
      pending      <= 16'h0000;
      pending_flag <= 1'b0;
      shadow       <= 16'h0000;
    end else begin
      if (cnt == CNT_MAX) begin
        cnt <= '0;
        idx <= idx + 2'd1;
      end else begin
        cnt <= cnt + CW'(1);
      end
      shadow <= shadow_d;
      if (frame_edge) begin
        pending_flag <= 1'b0;
      end else if (bus.bcd_valid) begin
        pending      <= bus.bcd_in;
        pending_flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bus.seg        <= SEG_OFF;
      bus.seg_dp     <= 1'b0;
      bus.dig_en_n   <= DIG_OFF_N;
      bus.frame_sync <= 1'b0;
    end else begin
      bus.frame_sync <= frame_edge;
      if (in_dead) begin
        bus.seg      <= SEG_OFF;
        bus.seg_dp   <= 1'b0;
        bus.dig_en_n <= DIG_OFF_N;
      end else begin
        bus.seg      <= (bus.blank_lz && lz[idx]) ? SEG_OFF : dec;
        bus.seg_dp   <= bus.dp_in[idx];
        bus.dig_en_n <= DIG_EN_N[idx];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Randomized + directed bench for seg7_scan_mux against a
// time-position reference model of the display.
module tb_seg7_scan_mux;

  localparam int SD = 20;
  localparam int DC = 4;
  localparam int FR = 4 * SD;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  seg7_scan_mux_if bus ();

  seg7_scan_mux #(
    .SCAN_DIV    (SD),
    .DEAD_CYCLES (DC)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  int          pos;
  logic [15:0] m_pend;
  logic [15:0] m_shown;
  logic        m_flag;

  function automatic logic [6:0] pat(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t pos=%0d got=%h exp=%h",
               tag, $time, pos, got, exp);
    end
  endtask

  task automatic model_reset();
    pos     = 0;
    m_pend  = 16'h0;
    m_shown = 16'h0;
    m_flag  = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_en"},  16'(bus.dig_en_n),   16'hF);
    chk({tag, "_seg"}, 16'(bus.seg),        16'h0);
    chk({tag, "_dp"},  16'(bus.seg_dp),     16'h0);
    chk({tag, "_fs"},  16'(bus.frame_sync), 16'h0);
  endtask

  // One clock: model advances with the inputs held for this edge,
  // outputs checked 1 time unit later, new inputs from next negedge.
  task automatic cycle();
    int p, slot, dg;
    logic [3:0] e_en;
    logic [6:0] e_seg;
    logic       e_dp;
    @(posedge CLK);
    p = pos % FR;
    if (p == 0) begin
      if (bus.bcd_valid) m_shown = bus.bcd_in;
      else if (m_flag)   m_shown = m_pend;
      m_flag = 1'b0;
    end else if (bus.bcd_valid) begin
      m_pend = bus.bcd_in;
      m_flag = 1'b1;
    end
    slot = p % SD;
    dg   = p / SD;
    if (slot < DC) begin
      e_en  = 4'hF;
      e_seg = 7'h0;
      e_dp  = 1'b0;
    end else begin
      e_en = ~(4'b1000 >> dg);
      if (bus.blank_lz && dg > 0 && (m_shown >> (4 * dg)) == 16'h0)
        e_seg = 7'h0;
      else
        e_seg = pat(4'((m_shown >> (4 * dg)) & 16'hF));
      e_dp = bus.dp_in[dg];
    end
    #1;
    chk("dig_en_n",   16'(bus.dig_en_n),   16'(e_en));
    chk("seg",        16'(bus.seg),        16'(e_seg));
    chk("seg_dp",     16'(bus.seg_dp),     16'(e_dp));
    chk("frame_sync", 16'(bus.frame_sync), 16'(p == 0));
    pos++;
    @(negedge CLK);
    bus.bcd_valid = 1'b0;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic strobe(input logic [15:0] v);
    bus.bcd_in    = v;
    bus.bcd_valid = 1'b1;
    cycle();
  endtask

  task automatic align(input int p);
    while (pos % FR != p) cycle();
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    for (int i = 0; i < 4; i++)
      v[4*i +: 4] = ($urandom_range(1, 0) == 0) ? 4'd0
                                                : 4'($urandom_range(15, 0));
    return v;
  endfunction

  initial begin
    bus.bcd_in    = 16'h0;
    bus.bcd_valid = 1'b0;
    bus.dp_in     = 4'b0;
    bus.blank_lz  = 1'b0;
    model_reset();

    repeat (3) begin
      @(posedge CLK);
      #1;
      chk_reset("rst_hold");
    end
    @(negedge CLK);
    RST_N = 1'b1;

    run(FR + 10);
    strobe(16'h1234);
    run(2 * FR);

    bus.blank_lz = 1'b1;
    strobe(16'h0050);
    run(2 * FR);
    bus.blank_lz = 1'b0;
    run(FR);
    bus.blank_lz = 1'b1;
    strobe(16'h0000);
    run(2 * FR);

    bus.dp_in = 4'b0010;
    strobe(16'h0A09);
    run(2 * FR);

    align(30);
    strobe(16'h1111);
    run(5);
    strobe(16'h2222);
    run(2 * FR);

    align(0);
    strobe(16'h4321);
    run(FR);

    align(30);
    @(posedge CLK);
    #3;
    RST_N = 1'b0;
    #1;
    chk_reset("rst_async");
    @(posedge CLK);
    #1;
    chk_reset("rst_held");
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
    run(FR);

    repeat (1500) begin
      bus.dp_in = 4'($urandom_range(15, 0));
      if ($urandom_range(15, 0) == 0)
        bus.blank_lz = ~bus.blank_lz;
      if ($urandom_range(9, 0) == 0) begin
        bus.bcd_in    = rand_bcd();
        bus.bcd_valid = 1'b1;
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
